wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that owns the single write port of the 32x32 register file (Address_3 / WriteEnable_3 / WriteData_3). It merges two result producers: the ALU, which cannot be stalled, and the load/store unit, which uses a valid/ready handshake. Load results are buffered in a small in-order FIFO. The block enforces write-after-write ordering and exports a pending-destination mask to the hazard logic.

## Interface
Parameters:
- DEPTH, 4, LSU result FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept an LSU result.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- WriteEnable_3  out  1  register file write enable (registered).
- Address_3  out  5  register file write address (registered).
- WriteData_3  out  32  register file write data (registered).
- pending_mask  out  32  bit r = 1 when a live FIFO entry targets xr; bit 0 is always 0.
- fifo_count  out  $clog2(DEPTH)+1  number of FIFO entries, including dead ones.

## Operation
- FIFO entry format: {live, rd, data}. Entries are kept in arrival order; read and write pointers wrap modulo DEPTH.
- lsu_ready = (fifo_count < DEPTH), computed from registered state only. A pop in the same cycle does not free a slot for a push.
- LSU handshake: a push happens when lsu_valid && lsu_ready. If lsu_rd == 0, the handshake still completes but nothing is pushed and fifo_count does not change.
- ALU win: alu_valid && alu_rd != 0. alu_valid with alu_rd == 0 is ignored and does not take the port.
- Port selection each cycle, with priority:
  1. ALU win: write alu_rd / alu_data.
  2. Otherwise, if the head entry is live: pop it and write its rd / data.
  3. Otherwise: no write.
- Dead head: it is popped in any cycle, including ALU-win cycles, and never produces a write. At most one pop per cycle.
- WAW kill: on an ALU win, every entry already stored whose rd == alu_rd has its live bit cleared in that cycle. An LSU result pushed in the same cycle with the same rd counts as younger: it stays live and is written later.
- pending_mask is the OR over live entries of (1 << rd). It is combinational from registered FIFO state and excludes the entry being pushed this cycle.
- FIFO full while ALU wins every cycle: the LSU waits through lsu_ready = 0. There is no starvation guard; the pipeline guarantees ALU idle cycles.

## Timing
- Reset (rst_n low, asynchronous): WriteEnable_3 = 0, Address_3 = 0, WriteData_3 = 0, FIFO empty, fifo_count = 0, pending_mask = 0, lsu_ready = 1.
- Reset mid-operation discards every buffered entry; no write is issued for them after release.
- Latency:
  - ALU: result accepted at edge N appears on the port from edge N to N+1, so it is written by the register file at edge N+1.
  - LSU: a push at edge N into an empty FIFO with no ALU win at N+1 pops at edge N+1 and is on the port from N+1 to N+2. There is no same-cycle bypass from lsu to the port.
- On no-write cycles, Address_3 and WriteData_3 hold their last values and WriteEnable_3 = 0.
- Simultaneous push and pop: fifo_count is unchanged, and the pointers advance independently.
- pending_mask and fifo_count update on the same edge as the FIFO state.

## Test plan
- Reset, then ALU pulse rd=5, data=0x1234_5678 at cycle 1 -> WriteEnable_3=1, Address_3=5, WriteData_3=0x1234_5678 during cycle 2; WriteEnable_3=0 in cycle 3.
- LSU push rd=7, data=0xA5A5_A5A5 with the ALU idle -> pending_mask=0x80 for one cycle, then a port write to x7 one cycle after the push; fifo_count goes 1 then 0.
- alu_valid held with distinct nonzero rd for 6 cycles while the LSU pushes 5 results (DEPTH=4) -> lsu_ready=0 after 4 accepted pushes, the 5th is held, and no LSU write occurs until the ALU goes idle; then the LSU results drain in order.
- LSU pushes rd=3 (0x11), then the ALU writes rd=3 (0x22) while that entry is queued -> only 0x22 is written to x3; the dead entry pops silently and pending_mask bit 3 clears at the kill edge.
- Same-cycle ALU rd=4 (0x1) and LSU push rd=4 (0x2), ALU idle afterward -> x4 is written with 0x1, then with 0x2.
- LSU push with rd=0 and ALU alu_rd=0 -> handshake completes, fifo_count stays 0, no WriteEnable_3; assert rst_n low with 3 entries queued -> all outputs return to their reset values asynchronously, and no writes occur after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU/LSU result inputs, register-file write port,
// and the hazard-facing status outputs.
interface wb_arbiter_if #(
   parameter int DEPTH = 4
);
   logic                     alu_valid;
   logic [4:0]               alu_rd;
   logic [31:0]              alu_data;
   logic                     lsu_valid;
   logic                     lsu_ready;
   logic [4:0]               lsu_rd;
   logic [31:0]              lsu_data;
   logic                     WriteEnable_3;
   logic [4:0]               Address_3;
   logic [31:0]              WriteData_3;
   logic [31:0]              pending_mask;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  WriteEnable_3, Address_3, WriteData_3,
      input  pending_mask, fifo_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output WriteEnable_3, Address_3, WriteData_3,
      output pending_mask, fifo_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: ALU results win immediately, LSU results
// queue in an in-order FIFO whose entries can be killed by younger ALU writes.
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] live_q;
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   logic             lsu_ready;
   logic             alu_win;
   logic             push;
   logic             head_valid;
   logic             head_live;
   logic             pop;
   logic             wr_head;
   logic [DEPTH-1:0] kill;
   logic [31:0]      pending;

   assign lsu_ready  = (count_q < CW'(DEPTH));
   assign alu_win    = bus.alu_valid && (bus.alu_rd != 5'd0);
   // rd == 0 completes the handshake but never occupies a slot
   assign push       = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
   assign head_valid = (count_q != '0);
   assign head_live  = head_valid && live_q[rd_ptr];
   // dead heads drain every cycle; live heads only when the ALU leaves the port free
   assign pop        = head_valid && (!head_live || !alu_win);
   assign wr_head    = head_live && !alu_win;

   always_comb begin
      kill = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill[i] = alu_win && (rd_q[i] == bus.alu_rd);
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i]) begin
            pending[rd_q[i]] = 1'b1;
         end
      end
      pending[0] = 1'b0;
   end

   // live bits are cleared on pop so only occupied entries contribute to the mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill[i]) begin
               live_q[i] <= 1'b0;
            end
         end
         if (pop) begin
            live_q[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + AW'(1);
         end
         if (push) begin
            live_q[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr]   <= bus.lsu_rd;
         data_q[wr_ptr] <= bus.lsu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.WriteEnable_3 <= 1'b0;
         bus.Address_3     <= 5'd0;
         bus.WriteData_3   <= 32'd0;
      end else begin
         bus.WriteEnable_3 <= alu_win || wr_head;
         if (alu_win) begin
            bus.Address_3   <= bus.alu_rd;
            bus.WriteData_3 <= bus.alu_data;
         end else if (wr_head) begin
            bus.Address_3   <= rd_q[rd_ptr];
            bus.WriteData_3 <= data_q[rd_ptr];
         end
      end
   end

   assign bus.lsu_ready    = lsu_ready;
   assign bus.pending_mask = pending;
   assign bus.fifo_count   = count_q;
endmodule
